// File: rtl/demux_pkg.sv
// Shared constants and types for the buffered 1-to-4 demultiplexer.
// Channel queues use a wrap bit on their pointers, so DEPTH must be a power of two.
package demux_pkg;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned NCH   = 4;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef logic [$clog2(NCH)-1:0] chan_t;
  typedef logic [WIDTH-1:0]       word_t;
  typedef logic [CNT_W-1:0]       cnt_t;

endpackage

// File: rtl/demux_1_4_4_if.sv
// Bus bundle for demux_1_4_4: one shared input stream and four output channels.
// The slave modport is the demux side; the master modport is the source/consumer side.
interface demux_1_4_4_if;
  import demux_pkg::*;

  logic               In_valid;
  logic               In_ready;
  word_t              D;
  chan_t              Sel;
  logic [NCH-1:0]     Out_valid;
  logic [NCH-1:0]     Out_ready;
  word_t              Q0, Q1, Q2, Q3;
  cnt_t               Cnt0, Cnt1, Cnt2, Cnt3;
  logic [NCH-1:0]     Full;

  modport slave (
    input  In_valid, D, Sel, Out_ready,
    output In_ready, Out_valid, Q0, Q1, Q2, Q3, Cnt0, Cnt1, Cnt2, Cnt3, Full
  );

  modport master (
    output In_valid, D, Sel, Out_ready,
    input  In_ready, Out_valid, Q0, Q1, Q2, Q3, Cnt0, Cnt1, Cnt2, Cnt3, Full
  );

endinterface

// File: rtl/chan_fifo.sv
// One output channel: DEPTH-entry queue with valid/ready head and a pop counter.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module chan_fifo
  import demux_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  word_t din,
  input  logic  pop_req,
  output logic  valid,
  output logic  full,
  output word_t head,
  output cnt_t  count
);

  logic [PTR_W:0]  wptr_q, rptr_q;
  word_t           mem_q [DEPTH];
  cnt_t            count_q;
  logic            pop;

  assign valid = (wptr_q != rptr_q);
  assign full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                 (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign pop   = valid & pop_req;
  // Head forced to zero when empty so stale storage never leaks out.
  assign head  = valid ? mem_q[rptr_q[PTR_W-1:0]] : '0;
  assign count = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q[PTR_W-1:0]] <= din;
        wptr_q                   <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q  <= rptr_q + 1'b1;
        count_q <= count_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_1_4_4.sv
// Buffered 1-to-4 demultiplexer: steers the input word into the queue chosen by Sel.
// In_ready depends only on Sel and queue state, never on any Out_ready.
module demux_1_4_4
  import demux_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  demux_1_4_4_if.slave  bus
);

  logic [NCH-1:0] push_en;
  logic [NCH-1:0] full;
  logic [NCH-1:0] valid;
  word_t          head [NCH];
  cnt_t           cnt  [NCH];
  logic           in_ready;

  assign in_ready = rst_n & ~full[bus.Sel];

  always_comb begin
    push_en = '0;
    if (bus.In_valid && in_ready) push_en[bus.Sel] = 1'b1;
  end

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    chan_fifo u_chan_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push_en[k]),
      .din     (bus.D),
      .pop_req (bus.Out_ready[k]),
      .valid   (valid[k]),
      .full    (full[k]),
      .head    (head[k]),
      .count   (cnt[k])
    );
  end

  assign bus.In_ready  = in_ready;
  assign bus.Out_valid = valid;
  assign bus.Full      = full;
  assign bus.Q0        = head[0];
  assign bus.Q1        = head[1];
  assign bus.Q2        = head[2];
  assign bus.Q3        = head[3];
  assign bus.Cnt0      = cnt[0];
  assign bus.Cnt1      = cnt[1];
  assign bus.Cnt2      = cnt[2];
  assign bus.Cnt3      = cnt[3];

endmodule

// File: tb/tb_demux_1_4_4.sv
// Self-checking bench for demux_1_4_4: queue-based reference model compared every
// cycle, plus hand-computed literal expectations for the directed scenarios.
module tb_demux_1_4_4;
  import demux_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  demux_1_4_4_if bus ();

  demux_1_4_4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] mq  [4][$];
  int         mcnt[4];
  logic [3:0] got [4][$];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  function automatic int q_of(input int k);
    case (k)
      0: return int'(bus.Q0);
      1: return int'(bus.Q1);
      2: return int'(bus.Q2);
      default: return int'(bus.Q3);
    endcase
  endfunction

  function automatic int cnt_of(input int k);
    case (k)
      0: return int'(bus.Cnt0);
      1: return int'(bus.Cnt1);
      2: return int'(bus.Cnt2);
      default: return int'(bus.Cnt3);
    endcase
  endfunction

  // Reference model: a word list per channel and a modulo-256 pop tally.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        mq[k].delete();
        mcnt[k] = 0;
      end
    end else begin
      bit do_push;
      do_push = bus.In_valid && (mq[bus.Sel].size() < DEPTH);
      for (int k = 0; k < 4; k++) begin
        if (mq[k].size() > 0 && bus.Out_ready[k]) begin
          void'(mq[k].pop_front());
          mcnt[k] = (mcnt[k] + 1) % 256;
        end
      end
      if (do_push) mq[bus.Sel].push_back(bus.D);
    end
  end

  // Per-cycle comparison and delivered-word capture.
  always @(negedge clk) begin
    int ev, ef, exp_rdy;
    ev = 0;
    ef = 0;
    for (int k = 0; k < 4; k++) begin
      if (mq[k].size() > 0)      ev |= (1 << k);
      if (mq[k].size() == DEPTH) ef |= (1 << k);
      chk($sformatf("q%0d", k), q_of(k), (mq[k].size() > 0) ? int'(mq[k][0]) : 0);
      chk($sformatf("cnt%0d", k), cnt_of(k), mcnt[k]);
      if (bus.Out_valid[k] && bus.Out_ready[k]) got[k].push_back(4'(q_of(k)));
    end
    exp_rdy = (rst_n && mq[bus.Sel].size() < DEPTH) ? 1 : 0;
    chk("out_valid", int'(bus.Out_valid), ev);
    chk("full", int'(bus.Full), ef);
    chk("in_ready", int'(bus.In_ready), exp_rdy);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds the word until accepted; waits counts cycles In_ready was low.
  task automatic push_word(input logic [1:0] s, input logic [3:0] d, output int waits);
    bit acc;
    acc   = 1'b0;
    waits = 0;
    bus.In_valid = 1'b1;
    bus.Sel      = s;
    bus.D        = d;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = bus.In_ready;
      @(posedge clk);
      #1;
      if (!acc) waits++;
    end
    bus.In_valid = 1'b0;
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  task automatic clear_got();
    for (int k = 0; k < 4; k++) got[k].delete();
  endtask

  int w;

  initial begin
    rst_n         = 1'b0;
    bus.In_valid  = 1'b0;
    bus.D         = '0;
    bus.Sel       = '0;
    bus.Out_ready = '0;
    cyc(2);
    chk("rst_out_valid", int'(bus.Out_valid), 0);
    chk("rst_in_ready", int'(bus.In_ready), 0);
    chk("rst_full", int'(bus.Full), 0);
    rst_n = 1'b1;
    cyc(1);

    // Single push to channel 1.
    push_word(2'd1, 4'hA, w);
    chk("t1_out_valid", int'(bus.Out_valid), 4'b0010);
    chk("t1_q1", int'(bus.Q1), 4'hA);
    chk("t1_q0q2q3", int'({bus.Q0, bus.Q2, bus.Q3}), 0);
    chk("t1_in_ready", int'(bus.In_ready), 1);

    // Fill channel 2, stall the third word, then drain.
    clear_got();
    push_word(2'd2, 4'h3, w);
    push_word(2'd2, 4'h5, w);
    chk("t2_full", int'(bus.Full), 4'b0100);
    bus.D        = 4'h7;
    bus.Sel      = 2'd2;
    bus.In_valid = 1'b1;
    #1 chk("t2_rdy_sel2", int'(bus.In_ready), 0);
    bus.Sel = 2'd0;
    #1 chk("t2_rdy_sel0", int'(bus.In_ready), 1);
    bus.Sel = 2'd2;
    fork
      push_word(2'd2, 4'h7, w);
      begin
        cyc(2);
        bus.Out_ready[2] = 1'b1;
      end
    join
    cyc(4);
    bus.Out_ready[2] = 1'b0;
    chk("t2_seq_len", got[2].size(), 3);
    if (got[2].size() == 3) chk("t2_seq", int'({got[2][0], got[2][1], got[2][2]}), 12'h357);

    // Push into full channel 0 while it is being popped.
    clear_got();
    push_word(2'd0, 4'h1, w);
    push_word(2'd0, 4'h2, w);
    chk("t3_full", int'(bus.Full), 4'b0001);
    bus.Out_ready[0] = 1'b1;
    push_word(2'd0, 4'h3, w);
    chk("t3_waits", w, 1);
    cyc(4);
    bus.Out_ready[0] = 1'b0;
    chk("t3_seq_len", got[0].size(), 3);
    if (got[0].size() == 3) chk("t3_seq", int'({got[0][0], got[0][1], got[0][2]}), 12'h123);

    // All four channels popped in one cycle.
    push_word(2'd0, 4'h9, w);
    push_word(2'd2, 4'h6, w);
    push_word(2'd3, 4'hC, w);
    chk("t4_valid_all", int'(bus.Out_valid), 4'b1111);
    bus.Out_ready = 4'hF;
    cyc(1);
    bus.Out_ready = 4'h0;
    chk("t4_valid_none", int'(bus.Out_valid), 0);
    chk("t4_cnts", int'({bus.Cnt0, bus.Cnt1, bus.Cnt2, bus.Cnt3}), 32'h04010401);

    // Counter wrap on channel 3 after a fresh reset.
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    bus.Out_ready[3] = 1'b1;
    for (int i = 0; i < 255; i++) push_word(2'd3, 4'(i), w);
    cyc(3);
    chk("t5_cnt3_255", int'(bus.Cnt3), 255);
    push_word(2'd3, 4'hF, w);
    cyc(3);
    chk("t5_cnt3_wrap", int'(bus.Cnt3), 0);
    chk("t5_others", int'({bus.Cnt0, bus.Cnt1, bus.Cnt2}), 0);
    bus.Out_ready = 4'h0;

    // Asynchronous reset mid-cycle with words queued.
    clear_got();
    push_word(2'd0, 4'h1, w);
    push_word(2'd1, 4'h2, w);
    chk("t6_pre_valid", int'(bus.Out_valid), 4'b0011);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", int'(bus.Out_valid), 0);
    chk("t6_async_q", int'({bus.Q0, bus.Q1, bus.Q2, bus.Q3}), 0);
    chk("t6_async_cnt", int'({bus.Cnt0, bus.Cnt1, bus.Cnt2, bus.Cnt3}), 0);
    chk("t6_async_rdy", int'(bus.In_ready), 0);
    cyc(2);
    rst_n = 1'b1;
    bus.Out_ready = 4'hF;
    cyc(3);
    bus.Out_ready = 4'h0;
    chk("t6_no_ghost", got[0].size() + got[1].size(), 0);
    chk("t6_post_valid", int'(bus.Out_valid), 0);

    cyc(1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
